// File: rtl/alu_arbiter.sv
// Two-requester front end for one shared combinational ALU.
// Round-robin grant, one operation in flight, registered response.
module alu_arbiter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [2:0]       req0_sel,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [2:0]       req1_sel,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [2:0]       alu_sel,
    input  logic [WIDTH-1:0] alu_y,
    input  logic             alu_zero,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_y,
    output logic             rsp_zero
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EXEC = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    logic [1:0]       state;
    logic             last_grant;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [2:0]       op_sel;
    logic             op_id;
    logic             grant_id;
    logic             take;

    // On a tie the requester not served last wins.
    always_comb begin
        grant_id = req1_valid;
        if (req0_valid && req1_valid) begin
            grant_id = ~last_grant;
        end
    end

    assign take       = (state == IDLE) && !rst && (req0_valid || req1_valid);
    assign req0_ready = take && !grant_id;
    assign req1_ready = take && grant_id;

    assign alu_a     = op_a;
    assign alu_b     = op_b;
    assign alu_sel   = (state == EXEC) ? op_sel : 3'b000;
    assign rsp_valid = (state == RESP);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            op_a       <= '0;
            op_b       <= '0;
            op_sel     <= 3'b000;
            op_id      <= 1'b0;
            rsp_id     <= 1'b0;
            rsp_y      <= '0;
            rsp_zero   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (take) begin
                        op_a   <= grant_id ? req1_a : req0_a;
                        op_b   <= grant_id ? req1_b : req0_b;
                        op_sel <= grant_id ? req1_sel : req0_sel;
                        op_id  <= grant_id;
                        state  <= EXEC;
                    end
                end
                EXEC: begin
                    rsp_y      <= alu_y;
                    rsp_zero   <= alu_zero;
                    rsp_id     <= op_id;
                    last_grant <= op_id;
                    state      <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: directed scenarios then random traffic,
// with a round-robin / latency reference model and a behavioural ALU.
module tb_alu_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  v = 2'b00;
    logic [31:0] a [2];
    logic [31:0] b [2];
    logic [2:0]  s [2];
    logic        req0_ready, req1_ready;
    logic [31:0] alu_a, alu_b, alu_y, rsp_y;
    logic [2:0]  alu_sel;
    logic        alu_zero, rsp_valid, rsp_ready, rsp_id, rsp_zero;

    int tests = 0;
    int failed = 0;
    int cyc = 0;
    int mode = 0;
    int xcnt [2] = '{0, 0};
    int seen [2] = '{0, 0};
    logic [1:0] done;

    typedef struct {
        logic        id;
        logic [31:0] y;
        logic        z;
        int          t;
        logic [2:0]  sel;
        logic [31:0] a;
        logic [31:0] b;
    } exp_t;
    exp_t sb [$];

    logic m_busy = 1'b0;
    logic m_last = 1'b1;
    logic post_rst = 1'b0;

    alu_arbiter #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(v[0]), .req0_ready(req0_ready),
        .req0_a(a[0]), .req0_b(b[0]), .req0_sel(s[0]),
        .req1_valid(v[1]), .req1_ready(req1_ready),
        .req1_a(a[1]), .req1_b(b[1]), .req1_sel(s[1]),
        .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
        .alu_y(alu_y), .alu_zero(alu_zero),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_y(rsp_y), .rsp_zero(rsp_zero)
    );

    function automatic logic [31:0] ref_alu(logic [31:0] x, logic [31:0] y,
                                            logic [2:0] op);
        case (op)
            3'd1:    return x + y;
            3'd2:    return x & y;
            3'd3:    return x - y;
            3'd4:    return x ^ y;
            3'd5:    return x << y[4:0];
            3'd6:    return ~(x | y);
            3'd7:    return x | y;
            default: return 32'd0;
        endcase
    endfunction

    assign alu_y    = ref_alu(alu_a, alu_b, alu_sel);
    assign alu_zero = (alu_y == 32'd0);

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor / reference model, evaluated mid-cycle.
    always @(negedge clk) begin
        logic [1:0] er;
        logic       erv;
        er = 2'b00;
        if (rst) begin
            chk("ready_in_reset", {30'd0, req1_ready, req0_ready}, 32'd0);
            sb.delete();
            m_busy   = 1'b0;
            m_last   = 1'b1;
            post_rst = 1'b1;
        end else begin
            if (post_rst) begin
                chk("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
                chk("reset_rsp_y", rsp_y, 32'd0);
                chk("reset_rsp_zero", {31'd0, rsp_zero}, 32'd0);
                chk("reset_rsp_id", {31'd0, rsp_id}, 32'd0);
                post_rst = 1'b0;
            end
            if (!m_busy) begin
                if (v[0] && v[1]) er = m_last ? 2'b01 : 2'b10;
                else er = v;
            end
            chk("grant", {30'd0, req1_ready, req0_ready}, {30'd0, er});
            erv = (sb.size() > 0) && (cyc >= sb[0].t + 2);
            chk("rsp_valid", {31'd0, rsp_valid}, {31'd0, erv});
            if (sb.size() > 0 && cyc == sb[0].t + 1) begin
                chk("alu_sel_exec", {29'd0, alu_sel}, {29'd0, sb[0].sel});
                chk("alu_a_exec", alu_a, sb[0].a);
                chk("alu_b_exec", alu_b, sb[0].b);
            end else begin
                chk("alu_sel_idle", {29'd0, alu_sel}, 32'd0);
            end
            if (rsp_valid && sb.size() > 0) begin
                chk("rsp_id", {31'd0, rsp_id}, {31'd0, sb[0].id});
                chk("rsp_y", rsp_y, sb[0].y);
                chk("rsp_zero", {31'd0, rsp_zero}, {31'd0, sb[0].z});
                if (rsp_ready) begin
                    void'(sb.pop_front());
                    m_busy = 1'b0;
                end
            end
            for (int i = 0; i < 2; i++) begin
                if (v[i] && (i == 0 ? req0_ready : req1_ready)) begin
                    exp_t e;
                    e.id  = 1'(i);
                    e.y   = ref_alu(a[i], b[i], s[i]);
                    e.z   = (e.y == 32'd0);
                    e.t   = cyc;
                    e.sel = s[i];
                    e.a   = a[i];
                    e.b   = b[i];
                    sb.push_back(e);
                    m_busy = 1'b1;
                    m_last = 1'(i);
                    xcnt[i]++;
                end
            end
        end
    end

    task automatic new_op(int i);
        a[i] = $urandom;
        b[i] = ($urandom_range(0, 3) == 0) ? a[i] : $urandom;
        s[i] = 3'($urandom_range(0, 7));
        v[i] = 1'b1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        done = 2'b00;
        for (int i = 0; i < 2; i++) begin
            if (xcnt[i] != seen[i]) begin
                seen[i] = xcnt[i];
                done[i] = 1'b1;
                if (mode != 0) new_op(i);
                else v[i] = 1'b0;
            end else if (mode == 2) begin
                if (!v[i] && $urandom_range(0, 2) == 0) new_op(i);
                else if (v[i] && $urandom_range(0, 19) == 0) v[i] = 1'b0;
            end
        end
        if (mode == 2) begin
            rsp_ready = ($urandom_range(0, 3) != 0);
            rst = ($urandom_range(0, 150) == 0);
        end
    endtask

    task automatic set_op(int i, logic [31:0] x, logic [31:0] y, logic [2:0] op);
        a[i] = x;
        b[i] = y;
        s[i] = op;
        v[i] = 1'b1;
    endtask

    task automatic wait_done(int i);
        int k;
        for (k = 0; k < 30; k++) begin
            step();
            if (done[i]) break;
        end
        if (k == 30) begin
            failed++;
            $display("FAIL handshake_timeout: req%0d got no ready, required ready within 30 cycles", i);
        end
    endtask

    task automatic idle(int n);
        for (int k = 0; k < n; k++) step();
    endtask

    initial begin
        int grants;
        a = '{32'd0, 32'd0};
        b = '{32'd0, 32'd0};
        s = '{3'd0, 3'd0};
        rsp_ready = 1'b1;
        done = 2'b00;
        idle(2);
        rst = 1'b0;
        idle(2);

        set_op(0, 32'd5, 32'd3, 3'b001);
        wait_done(0);
        idle(4);

        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        set_op(0, 32'hF0, 32'h0F, 3'b010);
        set_op(1, 32'd1, 32'd1, 3'b001);
        wait_done(0);
        wait_done(1);
        idle(4);

        mode = 1;
        new_op(0);
        new_op(1);
        grants = 0;
        for (int k = 0; k < 40 && grants < 6; k++) begin
            step();
            grants += int'(done[0]) + int'(done[1]);
        end
        chk("six_grants", grants, 6);
        mode = 0;
        v = 2'b00;
        idle(5);

        rsp_ready = 1'b0;
        set_op(0, 32'd7, 32'd9, 3'b011);
        wait_done(0);
        set_op(1, 32'd2, 32'd2, 3'b111);
        idle(6);
        rsp_ready = 1'b1;
        wait_done(1);
        idle(4);

        set_op(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'b111);
        wait_done(0);
        set_op(1, 32'h1234_5678, 32'h1234_5678, 3'b100);
        wait_done(1);
        set_op(0, 32'hABCD, 32'h1, 3'b000);
        wait_done(0);
        idle(4);

        set_op(1, 32'd4, 32'd4, 3'b001);
        wait_done(1);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        set_op(0, 32'd10, 32'd20, 3'b001);
        set_op(1, 32'd30, 32'd40, 3'b001);
        wait_done(0);
        wait_done(1);
        idle(4);

        mode = 2;
        idle(1500);
        mode = 0;
        rst = 1'b0;
        rsp_ready = 1'b1;
        v = 2'b00;
        idle(10);
        chk("drain", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, required end before 500000 time units");
        $fatal(1);
    end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter: WIDTH, default 32, data width of operands and result.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst  input  1  reset, synchronous, active-high.
REQ-004 Port: req0_valid  input  1  requester 0 has an operation pending.
REQ-005 Port: req0_ready  output  1  requester 0 operation accepted this cycle.
REQ-006 Port: req0_a, req0_b  input  WIDTH each  requester 0 operands.
REQ-007 Port: req0_sel  input  3  requester 0 ALU op code.
REQ-008 Port: req1_valid, req1_ready, req1_a, req1_b, req1_sel  same directions/widths/meaning as REQ-004..007, for requester 1.
REQ-009 Port: alu_a, alu_b  output  WIDTH  operands to the shared ALU.
REQ-010 Port: alu_sel  output  3  op code to the shared ALU.
REQ-011 Port: alu_y  input  WIDTH  ALU result (combinational from alu_a/alu_b/alu_sel).
REQ-012 Port: alu_zero  input  1  ALU zero flag.
REQ-013 Port: rsp_valid  output  1  result available.
REQ-014 Port: rsp_ready  input  1  consumer accepts result.
REQ-015 Port: rsp_id  output  1  index of requester that owns the result.
REQ-016 Port: rsp_y  output  WIDTH  registered result; rsp_zero  output  1  registered zero flag.

Function
REQ-017 FSM states: IDLE, EXEC, RESP; encoding free.
REQ-018 IDLE: no valid -> stay IDLE; any valid -> grant one requester, latch its a/b/sel and id, go EXEC.
REQ-019 Arbitration: one valid -> grant it; both valid -> grant requester not granted last (round-robin bit last_grant).
REQ-020 reqN_ready is combinational, high only in IDLE for the granted requester in that cycle; at most one ready high per cycle; ready never high outside IDLE.
REQ-021 Handshake: transfer occurs when reqN_valid and reqN_ready both high; requester holds inputs stable until transfer.
REQ-022 EXEC: alu_a/alu_b/alu_sel driven from latched operands; at the clock edge ending EXEC, capture alu_y into rsp_y and alu_zero into rsp_zero; update last_grant to granted id; go RESP.
REQ-023 Outside EXEC alu_sel SHALL be 3'b000; alu_a/alu_b hold latched operand values.
REQ-024 RESP: rsp_valid high; rsp_y/rsp_zero/rsp_id stable; rsp_ready high -> go IDLE; rsp_ready low -> stay RESP (stall, no new grant).
REQ-025 Latency: transfer in cycle t -> rsp_valid high in cycle t+2; minimum issue interval 3 cycles.
REQ-026 Op code 3'b000 accepted and executed as any other; result whatever ALU returns (0, zero=1).
REQ-027 No arithmetic performed in this block; result width WIDTH, no truncation or extension.
REQ-028 A requester dropping valid before transfer is permitted; no grant recorded for it.

Reset
REQ-029 rst high at rising edge: state IDLE, last_grant=1 (requester 0 wins first tie), rsp_valid=0, rsp_id=0, rsp_y=0, rsp_zero=0, latched operands=0, latched sel=0.
REQ-030 rst dominates all other inputs, including mid-EXEC or mid-RESP; in-flight operation discarded, no response issued.
REQ-031 During rst cycle req0_ready=req1_ready=0.

Verification
REQ-032 req0 a=5,b=3,sel=001, rsp_ready=1 -> req0_ready at t, rsp_valid at t+2 with rsp_y=8, rsp_zero=0, rsp_id=0.
REQ-033 Both valid after reset (req0 sel=010 a=0xF0 b=0x0F; req1 sel=001 a=1 b=1) -> req0 served first (rsp_y=0, rsp_zero=1), then req1 (rsp_y=2, rsp_zero=0, rsp_id=1).
REQ-034 Both valid continuously for 6 ops -> grants alternate 0,1,0,1,0,1; never two readies in one cycle.
REQ-035 rsp_ready low 5 cycles in RESP -> rsp_valid and rsp_y stable, both reqN_ready stay 0; rsp_ready high -> IDLE next cycle.
REQ-036 sel=111 a=b=0xFFFF_FFFF -> rsp_y=0xFFFF_FFFF, rsp_zero=0; sel=100 a=b=0x1234_5678 -> rsp_y=0, rsp_zero=1.
REQ-037 rst asserted in EXEC cycle -> next cycle IDLE, rsp_valid=0, rsp_y=0; next tie granted to requester 0.
